// File: rtl/alu_arb.sv
// alu_arb: two-requester arbiter sharing one 16-bit add/multiply ALU, with a valid/ready response.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

module alu16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  op,
  output logic [15:0] y
);
  always_comb begin
    y = 16'h0000;
    case (op)
      2'b01:   y = a + b;
      2'b10:   y = a * b;
      default: y = 16'h0000;
    endcase
  end
endmodule

// state | meaning
// IDLE  | no operation in flight; grant one valid requester and latch its operands
// EXEC  | ALU evaluates the latched operands; result is registered into rsp_data
// RESP  | rsp_valid high, response held until rsp_ready
module alu_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [1:0]  req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [1:0]  req1_op,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, b_q, alu_y;
  logic [1:0]  op_q;
  logic        id_q;
  logic        grant_id;
  logic        accept;
`ifdef ALU_ARB_RR_EN
  logic        prio_q;
`endif

  alu16 u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  // grant_id only matters when at least one requester is valid
  always_comb begin
`ifdef ALU_ARB_RR_EN
    grant_id = (req0_valid && req1_valid) ? prio_q : req1_valid;
`else
    grant_id = ~req0_valid;
`endif
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      op_q      <= 2'b00;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_id    <= 1'b0;
`ifdef ALU_ARB_RR_EN
      prio_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= grant_id ? req1_a  : req0_a;
        b_q  <= grant_id ? req1_b  : req0_b;
        op_q <= grant_id ? req1_op : req0_op;
        id_q <= grant_id;
`ifdef ALU_ARB_RR_EN
        prio_q <= ~grant_id;
`endif
      end
      if (state_q == EXEC) begin
        rsp_data  <= alu_y;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: transaction-level model compared every cycle plus directed literal checks.
// Honours ALU_ARB_RR_EN to select the expected arbitration order.

module tb_alu_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] rsp_data;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_ref(input longint a, input longint b, input int op);
    longint r;
    if (op == 1)      r = a + b;
    else if (op == 2) r = a * b;
    else              r = 0;
    return 16'(r & 64'hFFFF);
  endfunction

  // Transaction model: an operation accepted in cycle N shows its response from N+2 until handshake.
  bit          m_inflight = 0;
  int          m_acc_cyc  = 0;
  int          m_id       = 0;
  int          m_last     = 1;
  logic [15:0] m_result   = 16'h0000;
  int          cyc        = 0;

  always @(negedge clk) begin
    bit e_r0, e_r1, e_busy, e_vld, acc;
    int win;
    e_busy = m_inflight;
    e_vld  = m_inflight && (cyc >= m_acc_cyc + 2);
    e_r0 = 0; e_r1 = 0; acc = 0; win = 0;
    if (!rst && !m_inflight && (req0_valid || req1_valid)) begin
      acc = 1;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
        win = 1 - m_last;
`else
        win = 0;
`endif
      end else begin
        win = req1_valid ? 1 : 0;
      end
      e_r0 = (win == 0);
      e_r1 = (win == 1);
    end
    chk("model_busy", 32'(busy), 32'(e_busy));
    chk("model_req0_ready", 32'(req0_ready), 32'(e_r0));
    chk("model_req1_ready", 32'(req1_ready), 32'(e_r1));
    chk("model_rsp_valid", 32'(rsp_valid), 32'(e_vld));
    if (e_vld) begin
      chk("model_rsp_data", 32'(rsp_data), 32'(m_result));
      chk("model_rsp_id", 32'(rsp_id), 32'(m_id));
    end
    if (rst) begin
      m_inflight = 0;
      m_last     = 1;
    end else if (acc) begin
      m_inflight = 1;
      m_acc_cyc  = cyc;
      m_id       = win;
      m_last     = win;
      m_result   = (win == 0) ? alu_ref(longint'(req0_a), longint'(req0_b), int'(req0_op))
                              : alu_ref(longint'(req1_a), longint'(req1_b), int'(req1_op));
    end else if (e_vld && rsp_ready) begin
      m_inflight = 0;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry/exit at posedge+1 with the block idle; operands are scrambled after acceptance.
  task automatic run_one(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [15:0] exp);
    rsp_ready = 1'b1;
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; req1_valid = 1'b0;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; req0_valid = 1'b0;
    end
    @(negedge clk);
    chk("one_ready_granted", 32'(id == 0 ? req0_ready : req1_ready), 32'd1);
    chk("one_ready_other", 32'(id == 0 ? req1_ready : req0_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req0_op = ~op;
    req1_a = ~a; req1_b = ~b; req1_op = ~op;
    @(negedge clk);
    chk("one_exec_no_valid", 32'(rsp_valid), 32'd0);
    chk("one_exec_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("one_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("one_rsp_data", 32'(rsp_data), 32'(exp));
    chk("one_rsp_id", 32'(rsp_id), 32'(id));
    tick();
  endtask

  initial begin
    int g_id[$];
    int g_cyc[$];
    int exp_order[4];
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004; req0_op = 2'b01;
    req1_valid = 1'b0; req1_a = 16'h0000; req1_b = 16'h0000; req1_op = 2'b00;
    repeat (2) begin
      @(negedge clk);
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      tick();
    end
    rst = 1'b0;

    run_one(0, 16'h0003, 16'h0004, 2'b01, 16'h0007);
    run_one(1, 16'h0100, 16'h0100, 2'b10, 16'h0000);
    run_one(1, 16'h00FF, 16'h0002, 2'b10, 16'h01FE);
    run_one(0, 16'hFFFF, 16'h1234, 2'b11, 16'h0000);
    run_one(0, 16'hFFFF, 16'h0001, 2'b01, 16'h0000);
    run_one(1, 16'h1234, 16'h0010, 2'b00, 16'h0000);

    // Contention from a fresh reset so the priority pointer starts at requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_op = 2'b01;
    req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0002; req1_op = 2'b01;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 20 && g_id.size() < 4; i++) begin
      @(negedge clk);
      if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(i); end
      if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(i); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ALU_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    chk("cont_grant_count", 32'(g_id.size()), 32'd4);
    for (int i = 0; i < 4 && i < g_id.size(); i++)
      chk("cont_grant_order", 32'(g_id[i]), 32'(exp_order[i]));
    chk("cont_first_cycle", 32'(g_cyc.size() > 0 ? g_cyc[0] : -1), 32'd0);
    for (int i = 1; i < g_cyc.size(); i++)
      chk("cont_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    repeat (3) tick();

    // Backpressure with a competing requester held valid
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0006; req1_op = 2'b10;
    @(negedge clk);
    chk("bp_accept", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0; req1_a = 16'h0000;
    req0_valid = 1'b1; req0_a = 16'h0009; req0_b = 16'h0009; req0_op = 2'b01;
    @(negedge clk);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h001E);
      chk("bp_rsp_id", 32'(rsp_id), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    tick();

    // Reset while holding a response
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_op = 2'b01;
    @(negedge clk);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("rr_pre_valid", 32'(rsp_valid), 32'd1);
    chk("rr_pre_data", 32'(rsp_data), 32'h0002);
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("rr_post_valid", 32'(rsp_valid), 32'd0);
    chk("rr_post_data", 32'(rsp_data), 32'd0);
    chk("rr_post_busy", 32'(busy), 32'd0);
    tick();
    run_one(0, 16'h0009, 16'h0008, 2'b01, 16'h0011);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
